// File: rtl/picorv32_tb_mmio_if.sv
// picorv32 native memory bus as seen by the simulation-harness MMIO target.
interface picorv32_tb_mmio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        hit;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  hit, mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output hit, mem_ready, mem_rdata);
endinterface

// File: rtl/picorv32_tb_mmio.sv
// MMIO target for the simulation harness: console byte FIFO toward a host sink,
// sticky test-done/pass flags and a cycle watchdog.
module picorv32_tb_mmio #(
  parameter logic [31:0] CONSOLE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] DONE_ADDR      = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC     = 32'd123456789,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          READY_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  picorv32_tb_mmio_if.slave bus,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       cycle_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT      = 3'd1;
  localparam logic [2:0] S_ACT       = 3'd2;
  localparam logic [2:0] S_STALL     = 3'd3;
  localparam logic [2:0] S_DONE_WAIT = 3'd4;

  logic [2:0]    state;
  logic [31:0]   lat_cnt;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          stage_valid;
  logic [7:0]    stage_data;
  logic          is_console, is_done, is_push, fifo_full, complete, done_set, pop;
  logic [31:0]   count_ext, rd_val;

  assign bus.hit = bus.mem_valid && (bus.mem_addr[31:2] == CONSOLE_ADDR[31:2] ||
                                     bus.mem_addr[31:2] == DONE_ADDR[31:2]);

  assign is_console = addr_q == CONSOLE_ADDR[31:2];
  assign is_done    = addr_q == DONE_ADDR[31:2];
  assign is_push    = is_console && wstrb_q[0];
  // The staged byte counts toward occupancy so its deferred push can never overflow.
  assign fifo_full  = (fifo_count + CW'(stage_valid)) == CW'(FIFO_DEPTH);
  assign complete   = (state == S_ACT && !(is_push && fifo_full)) ||
                      (state == S_STALL && !fifo_full);
  assign done_set   = state == S_ACT && is_done && wstrb_q != 4'b0 && !done;

  assign char_valid = fifo_count != '0;
  assign char_data  = fifo_mem[rd_ptr];
  assign pop        = char_valid && char_ready;
  assign count_ext  = 32'(fifo_count);

  always_comb begin
    // NOTE: default first so every path assigns rd_val and no latch is inferred.
    rd_val = '0;
    if (wstrb_q == 4'b0 && is_console)
      rd_val = (count_ext > 32'd31) ? 32'd31 : count_ext;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      case (state)
        S_IDLE: if (bus.hit) begin
          addr_q  <= bus.mem_addr[31:2];
          wdata_q <= bus.mem_wdata;
          wstrb_q <= bus.mem_wstrb;
          lat_cnt <= 32'(READY_LATENCY - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 32'd1;
          else               state   <= S_ACT;
        end
        S_ACT: begin
          if (is_push && fifo_full) begin
            state <= S_STALL;
          end else begin
            bus.mem_ready <= 1'b1;
            bus.mem_rdata <= rd_val;
            state         <= S_DONE_WAIT;
          end
        end
        S_STALL: if (!fifo_full) begin
          bus.mem_ready <= 1'b1;
          state         <= S_DONE_WAIT;
        end
        // The core drops mem_valid during this cycle; ignoring it avoids a re-accept.
        S_DONE_WAIT: state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      stage_valid <= complete && is_push;
      stage_data  <= wdata_q[7:0];
      if (stage_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop)         rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(stage_valid) - CW'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; occupancy lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (stage_valid) fifo_mem[wr_ptr] <= stage_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (done_set) begin
        done <= 1'b1;
        pass <= wdata_q == PASS_MAGIC;
      end
      if (!done && !timeout) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        if (cycle_count == 32'(TIMEOUT_CYCLES - 1) && !done_set) timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_picorv32_tb_mmio.sv
// Bench for picorv32_tb_mmio: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of bus, console queue and flags.
module tb_picorv32_tb_mmio;
  localparam logic [31:0] CON   = 32'h1000_0000;
  localparam logic [31:0] DON   = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;
  localparam int          TMO   = 50;
  localparam int          DEPTH = 16;
  localparam int          RL    = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        char_ready;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        done, pass, timeout;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  picorv32_tb_mmio_if bus ();

  picorv32_tb_mmio #(
    .CONSOLE_ADDR(CON), .DONE_ADDR(DON), .PASS_MAGIC(MAGIC),
    .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .READY_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .done(done), .pass(pass), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_hit(input logic v, input logic [31:0] a);
    return v && (a[31:2] == CON[31:2] || a[31:2] == DON[31:2]);
  endfunction

  // Reference model: accepted requests complete RL+1 edges later unless the
  // console queue is full; acked bytes become visible to the sink one edge later.
  typedef struct { logic [7:0] data; int vis; } entry_t;
  entry_t      q[$];
  int          e = 0;
  bit          m_on = 0, busy = 0;
  int          due = 0, last_ack = -10;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  bit          m_ready = 0, m_read = 0, m_done = 0, m_pass = 0, m_to = 0;
  logic [31:0] m_rdata = '0, m_cc = '0;
  bit          t_old_done, t_old_to, t_pop, t_dset, t_push;
  int          t_occ, t_inf;

  always @(posedge clk) begin
    e++;
    if (!resetn) begin
      q.delete();
      busy = 0; last_ack = -10; m_ready = 0; m_read = 0; m_rdata = '0;
      m_done = 0; m_pass = 0; m_to = 0; m_cc = '0; m_on = 1;
    end else if (m_on) begin
      t_old_done = m_done; t_old_to = m_to; t_dset = 0;
      t_occ = q.size();
      t_inf = 0;
      foreach (q[i]) if (q[i].vis < e) t_inf++;
      t_pop = t_occ > 0 && q[0].vis <= e - 1 && char_ready;
      if (t_pop) void'(q.pop_front());
      m_ready = 0;
      if (busy && e >= due) begin
        t_push = r_addr[31:2] == CON[31:2] && r_wstrb[0];
        if (!(t_push && t_occ == DEPTH)) begin
          m_ready = 1; busy = 0; last_ack = e;
          m_read  = r_wstrb == 4'b0;
          if (m_read) m_rdata = (r_addr[31:2] == CON[31:2]) ? 32'(t_inf > 31 ? 31 : t_inf) : '0;
          if (t_push) q.push_back('{r_wdata[7:0], e + 1});
          if (r_addr[31:2] == DON[31:2] && r_wstrb != 4'b0 && !m_done) begin
            t_dset = 1; m_done = 1; m_pass = r_wdata == MAGIC;
          end
        end
      end else if (!busy && e >= last_ack + 2 && is_hit(bus.mem_valid, bus.mem_addr)) begin
        busy = 1; due = e + RL + 1;
        r_addr = bus.mem_addr; r_wdata = bus.mem_wdata; r_wstrb = bus.mem_wstrb;
      end
      if (!t_old_done && !t_old_to) begin
        if (m_cc == 32'(TMO - 1) && !t_dset) m_to = 1;
        if (m_cc != '1) m_cc++;
      end
    end
  end

  function automatic bit exp_cv();
    return q.size() > 0 && q[0].vis <= e;
  endfunction

  logic [7:0] recv[$];

  always @(negedge clk) begin
    if (m_on) begin
      check("hit", bus.hit, is_hit(bus.mem_valid, bus.mem_addr));
      check("mem_ready", bus.mem_ready, m_ready);
      if (m_ready && m_read) check("mem_rdata", bus.mem_rdata, m_rdata);
      check("char_valid", char_valid, exp_cv());
      if (exp_cv()) check("char_data", char_data, q[0].data);
      check("done", done, m_done);
      check("pass", pass, m_pass);
      check("timeout", timeout, m_to);
      check("cycle_count", cycle_count, m_cc);
      if (char_valid === 1'b1 && char_ready) recv.push_back(char_data);
    end
  end

  int          lat;
  logic [31:0] rd;
  bit          ack17;

  task automatic do_reset(input int n);
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic bus_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit rnd, output int l, output logic [31:0] r);
    bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    l = 0;
    forever begin
      @(negedge clk);
      l++;
      if (bus.mem_ready === 1'b1 || l >= 300) break;
      if (rnd) begin
        @(posedge clk);
        #1 char_ready = $urandom_range(0, 2) != 0;
      end
    end
    check("req_acked", bus.mem_ready, 1'b1);
    r = bus.mem_rdata;
    @(posedge clk);
    #1 bus.mem_valid = 1'b0;
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    char_ready = 1'b0; resetn = 1'b0;

    // Single console byte: accept edge + 2 edges to mem_ready, byte visible one cycle later.
    char_ready = 1'b1;
    do_reset(10);
    bus_req(CON, 32'h41, 4'b0001, 0, lat, rd);
    check("t1_latency", 32'(lat - 2), 32'd2);
    @(negedge clk);
    check("t1_char_valid", char_valid, 1'b1);
    check("t1_char_data", char_data, 8'h41);
    @(posedge clk); #1;

    // Fill the FIFO with the sink blocked; the 17th write stalls until the sink drains.
    char_ready = 1'b0;
    do_reset(5);
    recv.delete();
    for (int i = 0; i < 16; i++) bus_req(CON, 32'(i), 4'b0001, 0, lat, rd);
    ack17 = 0;
    fork
      begin bus_req(CON, 32'h10, 4'b0001, 0, lat, rd); ack17 = 1; end
      begin
        repeat (20) @(posedge clk);
        #1 check("t2_17th_stalled", 32'(ack17), 32'd0);
        char_ready = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    #1 check("t2_recv_count", 32'(recv.size()), 32'd17);
    for (int i = 0; i < 17 && i < recv.size(); i++) check("t2_recv_byte", recv[i], 32'(i));

    // DONE with the magic value, then a later write that must not change pass.
    do_reset(5);
    bus_req(DON, MAGIC, 4'hF, 0, lat, rd);
    @(negedge clk);
    check("t3_done", done, 1'b1);
    check("t3_pass", pass, 1'b1);
    check("t3_cc", cycle_count, 32'd3);
    repeat (80) @(negedge clk);
    check("t3_cc_frozen", cycle_count, 32'd3);
    check("t3_no_timeout", timeout, 1'b0);
    @(posedge clk); #1;
    bus_req(DON, 32'd0, 4'hF, 0, lat, rd);
    check("t3_pass_sticky", pass, 1'b1);
    do_reset(5);
    bus_req(DON, 32'hDEAD, 4'b0011, 0, lat, rd);
    check("t3_fail_done", done, 1'b1);
    check("t3_fail_pass", pass, 1'b0);

    // Watchdog expiry, then a DONE write landing on the expiry edge.
    do_reset(5);
    repeat (60) @(posedge clk);
    #1 check("t4_timeout", timeout, 1'b1);
    check("t4_cc_held", cycle_count, 32'd50);
    do_reset(5);
    repeat (47) @(posedge clk);
    #1 bus_req(DON, MAGIC, 4'hF, 0, lat, rd);
    check("t4_race_done", done, 1'b1);
    check("t4_race_timeout", timeout, 1'b0);
    check("t4_race_cc", cycle_count, 32'd50);

    // Reset while a console write is in its latency wait.
    char_ready = 1'b1;
    do_reset(5);
    bus.mem_valid = 1'b1; bus.mem_addr = CON; bus.mem_wdata = 32'h55; bus.mem_wstrb = 4'b0001;
    @(posedge clk);
    #1 resetn = 1'b0;
    bus.mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_ready", bus.mem_ready, 1'b0);
    check("t5_fifo_empty", char_valid, 1'b0);
    check("t5_flags", {done, pass, timeout}, 3'b000);
    @(posedge clk); #1;
    bus_req(CON, 32'h66, 4'b0001, 0, lat, rd);
    check("t5_after_latency", 32'(lat - 2), 32'd2);

    // Unmapped address is ignored; console read reports the queued byte count.
    char_ready = 1'b0;
    do_reset(5);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h0000_1000; bus.mem_wdata = 32'h77; bus.mem_wstrb = 4'b0001;
    repeat (6) begin
      @(negedge clk);
      check("t6_hit", bus.hit, 1'b0);
      check("t6_no_ready", bus.mem_ready, 1'b0);
    end
    @(posedge clk);
    #1 bus.mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) bus_req(CON, 32'hA0 + 32'(i), 4'b0001, 0, lat, rd);
    bus_req(CON, 32'h0, 4'b0000, 0, lat, rd);
    check("t6_rdata", rd, 32'd3);

    // Random traffic with a randomly throttled sink.
    do_reset(5);
    for (int t = 0; t < 200; t++) begin
      int          kind, gap;
      logic [31:0] tmp, addr, data;
      logic [3:0]  strb;
      kind = $urandom_range(0, 9);
      tmp  = $urandom;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      if (kind < 6)      addr = {CON[31:2], tmp[1:0]};
      else if (kind < 8) begin addr = {DON[31:2], tmp[1:0]}; if (tmp[8]) data = MAGIC; end
      else               addr = {4'h3, tmp[27:0]};
      if (kind < 8) begin
        bus_req(addr, data, strb, 1, lat, rd);
      end else begin
        bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_wdata = data; bus.mem_wstrb = strb;
        repeat (3) @(posedge clk);
        #1 bus.mem_valid = 1'b0;
      end
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1 char_ready = $urandom_range(0, 2) != 0;
      end
    end
    char_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
